// File: rtl/seq_divider_if.sv
// ----------------------------------------------------------------------------
// seq_divider_if
//   Start/busy/done handshake and data bundle for the sequential divider.
//   master : pipeline side (drives the request, observes status and results)
//   slave  : divider side (observes the request, drives status and results)
// Signals
//   start_i      request a division (sampled only while idle)
//   signed_i     1 = two's-complement DIV, 0 = unsigned DIVU
//   dividend_i   dividend, captured on the accepted start edge
//   divisor_i    divisor, captured on the accepted start edge
//   busy_o       operation in flight
//   done_o       single-cycle pulse, results valid in that cycle
//   quotient_o   quotient (LO), held until replaced
//   remainder_o  remainder (HI), held until replaced
//   div_zero_o   divisor was zero for the last completed operation
// ----------------------------------------------------------------------------
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] remainder_o;
  logic             div_zero_o;

  modport master (
    output start_i, signed_i, dividend_i, divisor_i,
    input  busy_o, done_o, quotient_o, remainder_o, div_zero_o
  );

  modport slave (
    input  start_i, signed_i, dividend_i, divisor_i,
    output busy_o, done_o, quotient_o, remainder_o, div_zero_o
  );
endinterface

// File: rtl/seq_divider.sv
// ----------------------------------------------------------------------------
// seq_divider
//   Iterative restoring divider for MIPS DIV/DIVU, one quotient bit per cycle.
//   Remainder feeds HI, quotient feeds LO. Signed operations divide the
//   magnitudes and fix up signs at the end (quotient negative when operand
//   signs differ, remainder takes the dividend's sign).
// Ports
//   clk_i  clock, rising edge
//   rst_i  asynchronous active-high reset, aborts any operation
//   bus    seq_divider_if.slave (request, status and results)
// Configuration
//   SEQ_DIV_EARLY_OUT_EN  when defined, |dividend| < |divisor| skips the
//                         iteration phase (q = 0, r = dividend).
// ----------------------------------------------------------------------------
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, dvd_raw_q;
  logic             q_neg_q, r_neg_q, dz_pending_q;
  logic             busy_q, done_q, div_zero_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;

  logic             dvd_neg, dvs_neg, accept, early_out, divisor_zero;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   shifted, trial;

  assign dvd_neg      = bus.signed_i & bus.dividend_i[WIDTH-1];
  assign dvs_neg      = bus.signed_i & bus.divisor_i[WIDTH-1];
  assign dvd_mag      = dvd_neg ? -bus.dividend_i : bus.dividend_i;
  assign dvs_mag      = dvs_neg ? -bus.divisor_i  : bus.divisor_i;
  assign divisor_zero = (bus.divisor_i == '0);

  // The done cycle is the tail of the operation, so a start seen there is
  // dropped; the earliest new request is the cycle after done.
  assign accept = (state_q == IDLE) && bus.start_i && !done_q;

`ifdef SEQ_DIV_EARLY_OUT_EN
  assign early_out = (dvd_mag < dvs_mag);
`else
  assign early_out = 1'b0;
`endif

  // Partial remainder shifted left with the next dividend bit pulled in,
  // one extra bit wide so the trial subtraction's borrow shows up as the MSB.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. Zero divisor and early-out both bypass CALC and go
  // directly to the sign/result stage.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (divisor_zero || early_out) ? FIX : CALC;
      CALC: if (count_q == CW'(1)) state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs. Early-out reuses the normal sign fix:
  // quotient 0 stays 0, and the dividend magnitude with the dividend's sign
  // reproduces the original dividend as the remainder.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q      <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      dvs_q        <= '0;
      dvd_raw_q    <= '0;
      q_neg_q      <= 1'b0;
      r_neg_q      <= 1'b0;
      dz_pending_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      div_zero_q   <= 1'b0;
      quotient_q   <= '0;
      remainder_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            dvd_raw_q    <= bus.dividend_i;
            dvs_q        <= dvs_mag;
            rem_q        <= early_out ? dvd_mag : '0;
            quo_q        <= early_out ? '0 : dvd_mag;
            count_q      <= CW'(WIDTH);
            q_neg_q      <= dvd_neg ^ dvs_neg;
            r_neg_q      <= dvd_neg;
            dz_pending_q <= divisor_zero;
            busy_q       <= 1'b1;
            div_zero_q   <= 1'b0;
          end
        end
        CALC: begin
          if (!trial[WIDTH]) begin
            rem_q <= trial[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= shifted[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
          end
          count_q <= count_q - CW'(1);
        end
        FIX: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          if (dz_pending_q) begin
            quotient_q  <= '1;
            remainder_q <= dvd_raw_q;
            div_zero_q  <= 1'b1;
          end else begin
            quotient_q  <= q_neg_q ? -quo_q : quo_q;
            remainder_q <= r_neg_q ? -rem_q : rem_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.quotient_o  = quotient_q;
  assign bus.remainder_o = remainder_q;
  assign bus.div_zero_o  = div_zero_q;

endmodule
